sw_debounce: RTL and testbench

//   Conditions a raw mechanical switch input into a clean, clock-synchronous level.
//   It also produces single-cycle rise/fall event pulses and a wrapping press counter.

---
 rtl/sw_debounce.sv | 118 +++++++++++
 tb/tb_sw_debounce.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Debounces a raw, asynchronous switch input into a clean synchronous level.
// Also produces one-cycle rise/fall pulses and a wrapping count of accepted presses.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_sw,
    output logic             o_sw,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_count
);

    // A one-cycle debounce still needs a 1-bit counter so the compare is well formed.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sw_q, sw_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        s1_d    = i_sw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        count_d = count_q;

        case (state_q)
            STABLE_LO: begin
                if (s2_q) begin
                    state_d = CHECK_HI;
                    cnt_d   = '0;
                end
            end
            CHECK_HI: begin
                if (!s2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    sw_d    = 1'b1;
                    rise_d  = 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s2_q) begin
                    state_d = CHECK_LO;
                    cnt_d   = '0;
                end
            end
            CHECK_LO: begin
                if (s2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    sw_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
        end
    end

    assign o_sw    = sw_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, CNT_W=2.
// Expected values are hand-derived from the two-flop sync plus four-sample qualification.
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw;
    logic       o_sw;
    logic       o_rise;
    logic       o_fall;
    logic [1:0] o_count;

    int total = 0;
    int bad   = 0;
    int rise_n = 0;
    int fall_n = 0;
    int both_n = 0;
    int r0;
    int f0;

    sw_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (2)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_sw     (sw),
        .o_sw     (o_sw),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_count  (o_count)
    );

    always #5 clk = ~clk;

    // Pulses last a full cycle, so sampling on the falling edge counts each exactly once.
    always @(negedge clk) begin
        rise_n <= rise_n + 32'(o_rise);
        fall_n <= fall_n + 32'(o_fall);
        both_n <= both_n + 32'(o_rise & o_fall);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 1'b1;

        // Reset held with the switch high: everything stays zero.
        repeat (5) begin
            tick();
            chk("rst_hold", 32'({o_sw, o_rise, o_fall, o_count}), 32'd0);
        end
        sw    = 1'b0;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("idle_lo", 32'(o_sw), 32'd0);

        // Clean press: accepted on the 7th edge (E+6) after the change.
        r0 = rise_n;
        sw = 1'b1;
        repeat (6) tick();
        chk("press_e5_sw", 32'(o_sw), 32'd0);
        tick();
        chk("press_sw", 32'(o_sw), 32'd1);
        chk("press_rise", 32'(o_rise), 32'd1);
        chk("press_cnt", 32'(o_count), 32'd1);
        tick();
        chk("press_rise_off", 32'(o_rise), 32'd0);
        chk("press_hold", 32'(o_sw), 32'd1);
        chk("press_rises", rise_n - r0, 32'd1);

        // Three-cycle low glitch is rejected.
        f0 = fall_n;
        sw = 1'b0;
        repeat (3) tick();
        sw = 1'b1;
        repeat (10) begin
            tick();
            chk("glitch_sw", 32'(o_sw), 32'd1);
        end
        chk("glitch_falls", fall_n - f0, 32'd0);

        // Ten-cycle low is accepted at E+6.
        sw = 1'b0;
        repeat (6) tick();
        chk("rel_e5_sw", 32'(o_sw), 32'd1);
        tick();
        chk("rel_sw", 32'(o_sw), 32'd0);
        chk("rel_fall", 32'(o_fall), 32'd1);
        chk("rel_cnt", 32'(o_count), 32'd1);
        repeat (3) tick();
        chk("rel_fall_off", 32'(o_fall), 32'd0);
        chk("rel_falls", fall_n - f0, 32'd1);

        // Bounce 1,0,1,0,1 every two cycles, then hold high.
        r0 = rise_n;
        f0 = fall_n;
        sw = 1'b1; repeat (2) tick();
        sw = 1'b0; repeat (2) tick();
        sw = 1'b1; repeat (2) tick();
        sw = 1'b0; repeat (2) tick();
        sw = 1'b1;
        repeat (6) begin
            tick();
            chk("bounce_wait", 32'(o_sw), 32'd0);
        end
        tick();
        chk("bounce_sw", 32'(o_sw), 32'd1);
        chk("bounce_rise", 32'(o_rise), 32'd1);
        chk("bounce_cnt", 32'(o_count), 32'd2);
        tick();
        chk("bounce_rises", rise_n - r0, 32'd1);
        chk("bounce_falls", fall_n - f0, 32'd0);

        // Release, then reset so the counter starts from zero for the wrap run.
        sw = 1'b0;
        repeat (8) tick();
        chk("pre_wrap_sw", 32'(o_sw), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("pre_wrap_cnt", 32'(o_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Five press/release cycles: counts 1,2,3,0,1.
        f0 = fall_n;
        for (int i = 0; i < 5; i++) begin
            sw = 1'b1;
            repeat (7) tick();
            chk("wrap_rise", 32'(o_rise), 32'd1);
            chk("wrap_cnt", 32'(o_count), 32'((i + 1) % 4));
            tick();
            sw = 1'b0;
            repeat (7) tick();
            chk("wrap_fall", 32'(o_fall), 32'd1);
            tick();
        end
        chk("wrap_falls", fall_n - f0, 32'd5);

        // Reset asserted between edges while in CHECK_HI with cnt=2.
        r0 = rise_n;
        sw = 1'b1;
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_cnt", 32'(o_count), 32'd0);
        chk("async_sw", 32'(o_sw), 32'd0);
        repeat (2) begin
            tick();
            chk("mid_rst_out", 32'({o_sw, o_rise}), 32'd0);
        end
        rst_n = 1'b1;
        repeat (6) tick();
        chk("post_rst_e5_sw", 32'(o_sw), 32'd0);
        tick();
        chk("post_rst_sw", 32'(o_sw), 32'd1);
        chk("post_rst_rise", 32'(o_rise), 32'd1);
        chk("post_rst_cnt", 32'(o_count), 32'd1);
        tick();
        chk("post_rst_rises", rise_n - r0, 32'd1);
        chk("no_both", both_n, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
